// File: rtl/div_result_bcd_converter.sv
// Converts one divider quotient/remainder pair to packed BCD with a
// double-dabble engine per channel, handing results off over valid/ready.

module div_result_bcd_lane #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [WIDTH-1:0]      din,
  output logic [4*DIGITS-1:0]   bcd_next
);
  logic [WIDTH-1:0]            bin, bin_next;
  logic [4*DIGITS-1:0]         bcd, adj;
  logic [4*DIGITS+WIDTH-1:0]   sh;

  // Digits are corrected independently before the shift; no carry crosses a digit.
  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++)
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
  end

  assign sh       = {adj, bin} << 1;
  assign bcd_next = sh[4*DIGITS+WIDTH-1:WIDTH];
  assign bin_next = sh[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin <= '0;
      bcd <= '0;
    end else if (load) begin
      bin <= din;
      bcd <= '0;
    end else if (step) begin
      bin <= bin_next;
      bcd <= bcd_next;
    end
  end
endmodule

module div_result_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int CW     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    quotient,
  input  logic [WIDTH-1:0]    remainder,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] q_bcd,
  output logic [4*DIGITS-1:0] r_bcd,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                        state, state_nxt;
  logic [CW-1:0]                 cnt;
  logic                          load, step, last;
  logic [1:0][WIDTH-1:0]         din;
  logic [1:0][4*DIGITS-1:0]      bcd_next;

  assign din  = {remainder, quotient};
  assign load = (state == IDLE) && in_valid;
  assign step = (state == CONV);
  assign last = step && (cnt == CW'(1));

  // Lane 0 = quotient, lane 1 = remainder.
  for (genvar l = 0; l < 2; l++) begin : g_lane
    div_result_bcd_lane #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .step     (step),
      .din      (din[l]),
      .bcd_next (bcd_next[l])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst;
        if (in_valid) state_nxt = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (load) cnt <= CW'(WIDTH);
    else if (step) cnt <= cnt - CW'(1);
  end

  // Results capture the final shift directly so they appear together with DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_bcd <= '0;
      r_bcd <= '0;
    end else if (last) begin
      q_bcd <= bcd_next[0];
      r_bcd <= bcd_next[1];
    end
  end
endmodule

// File: tb/tb_div_result_bcd_converter.sv
// Randomized and directed checks of the BCD converter against a decimal-arithmetic model.

module tb_div_result_bcd_converter;
  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  quotient = '0, remainder = '0;
  logic        in_ready, out_valid, busy;
  logic [11:0] q_bcd, r_bcd;

  int cyc = 0, last_acc = -1;
  int n_chk = 0, n_fail = 0;

  div_result_bcd_converter #(.WIDTH(8), .DIGITS(3), .CW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .quotient(quotient), .remainder(remainder), .out_valid(out_valid),
    .out_ready(out_ready), .q_bcd(q_bcd), .r_bcd(r_bcd), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] to_bcd(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] q, input logic [7:0] r, input int stall,
                      input bit noise, input bit chk_gap);
    int n;
    logic [11:0] eq, er;
    eq = to_bcd(int'(q));
    er = to_bcd(int'(r));
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    chk("ready_wait", in_ready, 1);
    in_valid = 1'b1; quotient = q; remainder = r;
    @(negedge clk);
    if (chk_gap && last_acc >= 0) chk("accept_gap", cyc - last_acc, 10);
    last_acc = cyc;
    chk("busy_conv", busy, 1);
    chk("ready_conv", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      if (noise) begin
        in_valid = 1'b1; quotient = 8'($urandom); remainder = 8'($urandom);
      end else in_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("latency", n, 8);
    chk("q_bcd", q_bcd, eq);
    chk("r_bcd", r_bcd, er);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_q", q_bcd, eq);
      chk("hold_r", r_bcd, er);
      chk("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("exit_valid", out_valid, 0);
    chk("exit_busy", busy, 0);
    chk("exit_ready", in_ready, 1);
    chk("idle_q", q_bcd, eq);
    chk("idle_r", r_bcd, er);
    in_valid = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q", q_bcd, 0);
    chk("rst_r", r_bcd, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("post_rst_ready", in_ready, 1);

    xfer(8'd14, 8'd2, 0, 1'b0, 1'b0);
    xfer(8'd255, 8'd0, 0, 1'b0, 1'b0);
    xfer(8'd0, 8'd199, 0, 1'b0, 1'b0);
    xfer(8'd123, 8'd45, 20, 1'b0, 1'b0);
    xfer(8'd77, 8'd250, 2, 1'b1, 1'b0);

    // Abort mid-conversion with an asynchronous reset.
    @(negedge clk);
    in_valid = 1'b1; quotient = 8'd200; remainder = 8'd201;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_q", q_bcd, 0);
    chk("abort_r", r_bcd, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_out", out_valid, 0);
    chk("abort_idle", in_ready, 1);
    xfer(8'd99, 8'd7, 0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++)
      xfer(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'b0);

    last_acc = -1;
    for (int v = 0; v < 256; v++)
      xfer(8'(v), ~8'(v), 0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
